sram_tile_reader: RTL and testbench

Upstream feeder for the 8x8 byte tile buffer in the 16-bit SRAM datapath. On a start pulse it fetches one 8-row x 8-byte tile from external synchronous SRAM (16-bit words, 18-bit word address). It splits each word into two bytes and writes them into the tile buffer with row/column coordinates, then pulses done. It owns the SRAM read address, which the tile buffer does not drive.

---
 rtl/sram_tile_reader_pkg.sv | 18 +
 rtl/sram_tile_reader_addr_gen.sv | 53 +++++
 rtl/sram_tile_reader.sv | 122 ++++++++++++
 tb/tb_sram_tile_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_tile_reader_pkg.sv
// Shared constants and FSM encoding for the SRAM-to-tile-buffer reader.
package sram_tile_reader_pkg;

  localparam int TILE_ROWS     = 8;
  localparam int WORDS_PER_ROW = 4;
  localparam int BYTE_W        = 8;
  localparam int SRAM_DW       = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT0   = 3'd3,
    ST_EMIT1   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sram_tile_reader_addr_gen.sv
// Row/word counters and tile word-address generation; the row base
// accumulates the stride on each row wrap, so no multiplier is needed.
module tile_addr_gen
  import sram_tile_reader_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_advance,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_stride,
  output logic [2:0]    o_row,
  output logic [1:0]    o_wcol,
  output logic [AW-1:0] o_word_addr,
  output logic          o_last
);

  logic [AW-1:0] r_row_base;
  logic [AW-1:0] r_stride;
  logic [2:0]    r_row;
  logic [1:0]    r_wcol;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_base <= '0;
      r_stride   <= '0;
      r_row      <= '0;
      r_wcol     <= '0;
    end else if (i_load) begin
      r_row_base <= i_base;
      r_stride   <= i_stride;
      r_row      <= '0;
      r_wcol     <= '0;
    end else if (i_advance) begin
      if (r_wcol == 2'(WORDS_PER_ROW - 1)) begin
        r_wcol     <= '0;
        r_row      <= r_row + 3'd1;
        r_row_base <= r_row_base + r_stride;
      end else begin
        r_wcol <= r_wcol + 2'd1;
      end
    end
  end

  // Sum is AW bits wide, so wrap past the top of SRAM is silent.
  assign o_word_addr = r_row_base + {{(AW-2){1'b0}}, r_wcol};
  assign o_row       = r_row;
  assign o_wcol      = r_wcol;
  assign o_last      = (r_row == 3'(TILE_ROWS - 1)) && (r_wcol == 2'(WORDS_PER_ROW - 1));

endmodule

// File: rtl/sram_tile_reader.sv
// Fetches one 8x8 byte tile from 16-bit SRAM and writes it, big-endian
// within each word, into the tile buffer in raster order.
module sram_tile_reader
  import sram_tile_reader_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_stride,
  output logic [AW-1:0] sram_addr,
  output logic          sram_ren,
  input  logic [DW-1:0] sram_rdata,
  output logic          byte_wen,
  output logic [7:0]    byte_data,
  output logic [2:0]    tile_i,
  output logic [2:0]    tile_j,
  output logic          busy,
  output logic          done
);

  state_t               r_state;
  state_t               w_next;
  logic [SRAM_DW-1:0]   r_word;
  logic                 w_load;
  logic                 w_advance;
  logic [2:0]           w_row;
  logic [1:0]           w_wcol;
  logic [AW-1:0]        w_word_addr;
  logic                 w_last;

  tile_addr_gen #(.AW(AW)) u_addr_gen (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_load      (w_load),
    .i_advance   (w_advance),
    .i_base      (base_addr),
    .i_stride    (row_stride),
    .o_row       (w_row),
    .o_wcol      (w_wcol),
    .o_word_addr (w_word_addr),
    .o_last      (w_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_CAPTURE) r_word <= sram_rdata[SRAM_DW-1:0];
    end
  end

  // Counters only move at the end of EMIT1, so the address stays stable
  // from ISSUE through EMIT1 without a separate holding register.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_advance = 1'b0;
    sram_addr = '0;
    sram_ren  = 1'b0;
    byte_wen  = 1'b0;
    byte_data = '0;
    tile_i    = '0;
    tile_j    = '0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        sram_ren  = 1'b1;
        sram_addr = w_word_addr;
        tile_i    = w_row;
        tile_j    = {w_wcol, 1'b0};
        w_next    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        sram_addr = w_word_addr;
        tile_i    = w_row;
        tile_j    = {w_wcol, 1'b0};
        w_next    = ST_EMIT0;
      end
      ST_EMIT0: begin
        sram_addr = w_word_addr;
        byte_wen  = 1'b1;
        byte_data = r_word[15:8];
        tile_i    = w_row;
        tile_j    = {w_wcol, 1'b0};
        w_next    = ST_EMIT1;
      end
      ST_EMIT1: begin
        sram_addr = w_word_addr;
        byte_wen  = 1'b1;
        byte_data = r_word[7:0];
        tile_i    = w_row;
        tile_j    = {w_wcol, 1'b1};
        if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_advance = 1'b1;
          w_next    = ST_ISSUE;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sram_tile_reader.sv
// Directed bench for sram_tile_reader: SRAM model, per-cycle tile observer,
// scoreboard of expected addresses/bytes, and a final report.
module tb_sram_tile_reader;

  localparam int AW = 18;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] row_stride;
  logic [AW-1:0] sram_addr;
  logic          sram_ren;
  logic [15:0]   sram_rdata;
  logic          byte_wen;
  logic [7:0]    byte_data;
  logic [2:0]    tile_i;
  logic [2:0]    tile_j;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;

  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] obs_addr_q[$];
  int            done_cyc_q[$];

  sram_tile_reader #(.AW(AW), .DW(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .sram_addr  (sram_addr),
    .sram_ren   (sram_ren),
    .sram_rdata (sram_rdata),
    .byte_wen   (byte_wen),
    .byte_data  (byte_data),
    .tile_i     (tile_i),
    .tile_j     (tile_j),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) gcyc <= gcyc + 1;

  // SRAM word at address a holds bytes {2a, 2a+1} (mod 256).
  function automatic logic [15:0] sram_word(input logic [AW-1:0] a);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(a * 2);
    lo = 8'(a * 2 + 1);
    return {hi, lo};
  endfunction

  initial sram_rdata = '0;
  always @(posedge clock) if (sram_ren) sram_rdata <= sram_word(sram_addr);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, gcyc);
    end
  endtask

  task automatic build_expected(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    logic [AW-1:0] a;
    logic [AW-1:0] row_v;
    logic [AW-1:0] wc_v;
    logic [15:0]   w;
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < 32; k++) begin
      row_v = AW'(k / 4);
      wc_v  = AW'(k % 4);
      a     = base + row_v * stride + wc_v;
      exp_addr_q.push_back(a);
      w = sram_word(a);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  // ---------------- driver / observer ----------------
  // Entered just after a negedge with the DUT idle. Cycle c is the c-th
  // cycle after the edge that accepts start.
  task automatic run_tile(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input int xs_a, input int xs_b, input int reset_at);
    int nbytes;
    int nren;
    int ndone;
    nbytes = 0;
    nren   = 0;
    ndone  = 0;
    build_expected(base, stride);
    obs_addr_q.delete();
    base_addr  = base;
    row_stride = stride;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    base_addr  = base ^ 18'h15555;
    row_stride = stride + 18'd3;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clock);
      if (reset_at == c) begin
        reset_n = 1'b0;
        #1;
        chk("reset_outputs", {sram_addr, sram_ren, byte_wen, byte_data, tile_i, tile_j, busy, done}, 64'd0);
        return;
      end
      if (sram_ren) begin
        nren++;
        obs_addr_q.push_back(sram_addr);
        chk("addr_no_x", 64'($isunknown(sram_addr)), 64'd0);
        if (exp_addr_q.size() > 0) chk("sram_addr", sram_addr, exp_addr_q.pop_front());
        else chk("extra_ren", nren, 32);
      end
      if (byte_wen) begin
        chk("wen_cycle", c, 3 + (nbytes / 2) * 4 + (nbytes % 2));
        if (exp_q.size() > 0) chk("byte_data", byte_data, exp_q.pop_front());
        else chk("extra_byte", nbytes + 1, 64);
        chk("tile_i", tile_i, nbytes / 8);
        chk("tile_j", tile_j, nbytes % 8);
        nbytes++;
      end
      if (done) begin
        ndone++;
        chk("done_cycle", c, 129);
        done_cyc_q.push_back(gcyc);
      end
      chk("busy", busy, (c <= 129));
      if (c == xs_a || c == xs_b) begin
        start     = 1'b1;
        base_addr = 18'h2AAAA;
      end else begin
        start = 1'b0;
      end
    end
    chk("byte_count", nbytes, 64);
    chk("ren_count", nren, 32);
    chk("done_count", ndone, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle_quiet", {sram_ren, byte_wen, busy, done, sram_addr}, 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    row_stride = '0;
    repeat (3) @(negedge clock);
    chk("rst_addr", sram_addr, 0);
    chk("rst_ctrl", {sram_ren, byte_wen, busy, done}, 0);
    chk("rst_data", {byte_data, tile_i, tile_j}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    idle_cycles(2);

    // Smoke: byte_data counts 0..63 in raster order.
    run_tile(18'h0, 18'd4, 0, 0, 0);
    idle_cycles(2);

    // Stride: rows 640 words apart starting at 0x100.
    run_tile(18'h00100, 18'd640, 0, 0, 0);
    chk("stride_a0", obs_addr_q[0], 18'h00100);
    chk("stride_a3", obs_addr_q[3], 18'h00103);
    chk("stride_row1", obs_addr_q[4], 18'h00380);
    chk("stride_row7", obs_addr_q[28], 18'h01280);
    chk("stride_last", obs_addr_q[31], 18'h01283);
    idle_cycles(2);

    // Wrap past the top of the 18-bit address space.
    run_tile(18'h3FFFE, 18'd2, 0, 0, 0);
    chk("wrap_a0", obs_addr_q[0], 18'h3FFFE);
    chk("wrap_a1", obs_addr_q[1], 18'h3FFFF);
    chk("wrap_a2", obs_addr_q[2], 18'h00000);
    chk("wrap_a3", obs_addr_q[3], 18'h00001);
    chk("wrap_row1", obs_addr_q[4], 18'h00000);
    idle_cycles(2);

    // Start pulses mid-tile and in DONE are ignored.
    run_tile(18'h0, 18'd4, 50, 129, 0);
    idle_cycles(4);

    // Asynchronous reset mid-tile, then a clean tile.
    run_tile(18'h0, 18'd4, 0, 0, 60);
    repeat (3) begin
      @(negedge clock);
      chk("in_reset", {sram_ren, byte_wen, busy, done, sram_addr}, 64'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    idle_cycles(1);
    run_tile(18'h0, 18'd4, 0, 0, 0);

    // Back-to-back: second start in the first IDLE cycle after done.
    done_cyc_q.delete();
    run_tile(18'h0, 18'd4, 0, 0, 0);
    run_tile(18'h00040, 18'd4, 0, 0, 0);
    chk("b2b_done_count", done_cyc_q.size(), 2);
    if (done_cyc_q.size() == 2) chk("b2b_done_gap", done_cyc_q[1] - done_cyc_q[0], 130);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
